// File: rtl/la_trace_decoder.sv
// Logic-analyzer trace decoder: replays RLE words {rc, data} as a per-sample stream.
// Optional sample timestamp counter enabled by `define LA_DEC_TIMESTAMP_EN.
module la_trace_decoder #(
  parameter int pDATA_WIDTH = 32,
  parameter int LA_WIDTH    = 24,
  parameter int RC_WIDTH    = 8
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cfg_enable,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [LA_WIDTH-1:0]    out_data,
  output logic                   out_gap,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [31:0]            out_ts,
  output logic [7:0]             gap_cnt,
  output logic [7:0]             err_cnt,
  output logic [15:0]            pkt_cnt,
  output logic                   err_sticky
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [LA_WIDTH-1:0] hold_q, hold_d;
  logic [RC_WIDTH-1:0] remain_q, remain_d;
  logic [7:0]          gap_q, gap_d;
  logic [7:0]          err_q, err_d;
  logic [15:0]         pkt_q, pkt_d;
  logic                sticky_q, sticky_d;

  logic [RC_WIDTH-1:0] w_rc;
  logic [LA_WIDTH-1:0] w_data;
  logic                acc, smp, done;

  assign w_rc   = s_tdata[LA_WIDTH+RC_WIDTH-1:LA_WIDTH];
  assign w_data = s_tdata[LA_WIDTH-1:0];

  // Slot frees up on the last sample of a run, so the next word chains without a bubble.
  assign done = (state_q == S_IDLE)
              | (out_rdy & (state_q == S_GAP))
              | (out_rdy & (state_q == S_PLAY) & (remain_q == 1));

  assign s_tready = cfg_enable & ~axis_rst & done;
  assign out_vld  = cfg_enable & (state_q != S_IDLE);
  assign out_gap  = (state_q == S_GAP);
  assign out_data = (state_q == S_PLAY) ? hold_q : '0;
  assign acc      = s_tvalid & s_tready;
  assign smp      = out_vld & out_rdy;

  assign gap_cnt    = gap_q;
  assign err_cnt    = err_q;
  assign pkt_cnt    = pkt_q;
  assign err_sticky = sticky_q;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    remain_d = remain_q;
    gap_d    = gap_q;
    err_d    = err_q;
    pkt_d    = pkt_q;
    sticky_d = sticky_q;
    if (acc && s_tlast) pkt_d = pkt_q + 16'd1;
    if (!cfg_enable) begin
      state_d = S_IDLE;
    end else begin
      if (smp && state_q == S_PLAY && remain_q != 1)
        remain_d = remain_q - 1'b1;
      if (done) begin
        state_d = S_IDLE;
        if (acc) begin
          if (s_tdata == '0) begin
            state_d = S_GAP;
            if (gap_q != 8'hFF) gap_d = gap_q + 8'd1;
          end else if (w_rc == '0) begin
            sticky_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end else begin
            state_d  = S_PLAY;
            hold_d   = w_data;
            remain_d = w_rc;
          end
        end
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      remain_q <= '0;
      gap_q    <= '0;
      err_q    <= '0;
      pkt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      remain_q <= remain_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
      pkt_q    <= pkt_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef LA_DEC_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;

  assign ts_d   = smp ? ts_q + 32'd1 : ts_q;
  assign out_ts = ts_q;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) ts_q <= '0;
    else          ts_q <= ts_d;
  end
`else
  assign out_ts = 32'h0;
`endif

endmodule

// File: tb/tb_la_trace_decoder.sv
// Bench for la_trace_decoder: scoreboard of expected samples, pushed on word
// acceptance and popped on each sample handshake.
module tb_la_trace_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [23:0] odata;
  logic        ogap;
  logic        ovld;
  logic        ordy = 1'b1;
  logic [31:0] ots;
  logic [7:0]  gcnt, ecnt;
  logic [15:0] pcnt;
  logic        sticky;

  int checks = 0;
  int errors = 0;

  logic [24:0] q[$];
  int          ts_m = 0;
  int          gap_m = 0, err_m = 0, pkt_m = 0;
  int          cyc = 0;
  logic        stall_p = 1'b0;
  logic [24:0] stall_v;
  logic        mon_on = 1'b1;

  always #5 clk = ~clk;

  la_trace_decoder dut (
    .axis_clk   (clk),
    .axis_rst   (rst),
    .cfg_enable (en),
    .s_tdata    (tdata),
    .s_tvalid   (tvalid),
    .s_tlast    (tlast),
    .s_tready   (tready),
    .out_data   (odata),
    .out_gap    (ogap),
    .out_vld    (ovld),
    .out_rdy    (ordy),
    .out_ts     (ots),
    .gap_cnt    (gcnt),
    .err_cnt    (ecnt),
    .pkt_cnt    (pcnt),
    .err_sticky (sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ts();
`ifdef LA_DEC_TIMESTAMP_EN
    return ts_m;
`else
    return 32'h0;
`endif
  endfunction

  // Monitor: compare every handshaked sample and hold-under-stall.
  always @(negedge clk) begin
    logic [24:0] e;
    cyc++;
    if (mon_on && !rst) begin
      if (stall_p && ovld)
        chk("stall_hold", {7'd0, ogap, odata}, {7'd0, stall_v});
      stall_p = ovld && !ordy;
      stall_v = {ogap, odata};
      if (ovld && ordy) begin
        if (q.size() == 0) begin
          chk("unexpected_sample", {7'd0, ogap, odata}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("sample", {7'd0, ogap, odata}, {7'd0, e});
          chk("ts", ots, exp_ts());
          ts_m++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic last);
    int n = 0;
    tdata = w; tvalid = 1'b1; tlast = last;
    forever begin
      @(negedge clk);
      if (tready) break;
      n++;
      if (n > 600) begin
        chk("accept_timeout", 32'd0, 32'd1);
        tvalid = 1'b0; tlast = 1'b0;
        return;
      end
    end
    if (last) pkt_m = (pkt_m + 1) & 16'hFFFF;
    if (w == 32'd0) begin
      q.push_back({1'b1, 24'd0});
      if (gap_m < 255) gap_m++;
    end else if (w[31:24] == 8'd0) begin
      if (err_m < 255) err_m++;
    end else begin
      for (int i = 0; i < int'(w[31:24]); i++) q.push_back({1'b0, w[23:0]});
    end
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk(tag, {31'd0, ovld}, 32'd0);
    chk({tag, "_q"}, q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int done;
    #2;
    chk("rst_tready", {31'd0, tready}, 32'd0);
    chk("rst_vld", {31'd0, ovld}, 32'd0);
    chk("rst_cnts", {gcnt, ecnt, pcnt}, 32'd0);
    chk("rst_ts", ots, 32'd0);
    en = 1'b1;
    #1;
    chk("rst_tready_en", {31'd0, tready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: single 3-sample run, latency one cycle
    send(32'h03ABCDEF, 1'b1);
    @(negedge clk);
    chk("t1_latency_vld", {31'd0, ovld}, 32'd1);
    @(posedge clk); #1;
    drain("t1_idle");

    // 2: back-to-back words, no bubble
    send(32'h02111111, 1'b0);
    done = cyc;
    send(32'h01222222, 1'b1);
    chk("t2_accept_cycle", cyc - done, 32'd2);
    @(negedge clk);
    chk("t2_third_vld", {31'd0, ovld}, 32'd1);
    @(posedge clk); #1;
    drain("t2_idle");

    // 3: null packet
    send(32'h00000000, 1'b0);
    drain("t3_idle");
    chk("t3_gap_cnt", gcnt, gap_m);

    // 4: malformed word dropped
    send(32'h00000001, 1'b1);
    @(negedge clk);
    chk("t4_no_vld", {31'd0, ovld}, 32'd0);
    chk("t4_err_cnt", ecnt, err_m);
    chk("t4_sticky", {31'd0, sticky}, 32'd1);
    @(posedge clk); #1;
    send(32'h01000005, 1'b0);
    drain("t4_idle");

    // 5: stall pattern on a 4-sample run
    send(32'h04123456, 1'b0);
    done = 0;
    for (int i = 0; i < 7; i++) begin
      ordy = pat[i][0];
      @(negedge clk);
      chk("t5_tready", {31'd0, tready},
          {31'd0, (pat[i] == 1 && done == 3)});
      if (ovld && ordy) done++;
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    chk("t5_samples", done, 32'd4);
    drain("t5_idle");

    // long run then seamless follow-up
    send(32'hFF0000AA, 1'b0);
    send(32'h01000BBB, 1'b1);
    drain("rc255_idle");
    chk("pkt_cnt", pcnt, pkt_m);

    // disable mid-run discards remainder, counters hold
    send(32'h05777777, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    q.delete();
    @(negedge clk);
    chk("dis_vld", {31'd0, ovld}, 32'd0);
    chk("dis_tready", {31'd0, tready}, 32'd0);
    chk("dis_ts", ots, exp_ts());
    chk("dis_gap", gcnt, gap_m);
    @(posedge clk); #1;
    en = 1'b1;
    send(32'h01000042, 1'b0);
    drain("reen_idle");

    // counter saturation
    for (int i = 0; i < 256; i++) send(32'h00000000, 1'b0);
    drain("sat_idle");
    chk("gap_sat", gcnt, 32'hFF);
    for (int i = 0; i < 256; i++) send(32'h00000003, 1'b0);
    chk("err_sat", ecnt, 32'hFF);
    chk("gap_model", gcnt, gap_m);

    // 6: async reset during 3rd of 8 samples
    send(32'h08ABCABC, 1'b0);
    while (q.size() > 6) @(negedge clk);
    #2;
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_vld_async", {31'd0, ovld}, 32'd0);
    chk("t6_cnts", {gcnt, ecnt, pcnt}, 32'd0);
    chk("t6_sticky", {31'd0, sticky}, 32'd0);
    q.delete();
    ts_m = 0; gap_m = 0; err_m = 0; pkt_m = 0;
    stall_p = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    mon_on = 1'b1;
    done = 0;
    repeat (10) begin
      @(negedge clk);
      if (ovld) done++;
    end
    chk("t6_no_samples", done, 32'd0);
    chk("t6_ts", ots, 32'd0);
    @(posedge clk); #1;
    send(32'h02456789, 1'b1);
    drain("t6_resume");
    chk("t6_pkt", pcnt, pkt_m);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
